// File: rtl/sprite_pkg.sv
// Shared constants, coordinate type and helpers for the sprite compositor.
package sprite_pkg;
  localparam int NUM_SPR_DEF = 4;
  localparam int SCR_W_DEF   = 1024;
  localparam int SCR_H_DEF   = 768;
  localparam logic [11:0] XPARENT_KEY = 12'h000;

  // Wide enough for (pixel - origin) with 12/13-bit world coordinates.
  localparam int COORD_W = 16;
  typedef logic signed [COORD_W-1:0] coord_t;

  // Background is encoded one past the last sprite index.
  function automatic int layer_bg(int num_spr);
    return num_spr;
  endfunction

  function automatic logic in_span(coord_t d, int span);
    return (d >= 0) && (d < coord_t'(span));
  endfunction
endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel, sprite-position, ROM and composed-pixel bus of the sprite compositor.
interface sprite_compositor_if #(
  parameter int NUM_SPR   = 4,
  parameter int POS_W     = 12,
  parameter int ADDR_W    = 14,
  parameter int COLOR_W   = 12,
  parameter int BG_ADDR_W = 16,
  parameter int LAYER_W   = $clog2(NUM_SPR) + 1
);
  logic [10:0]              pixel_row;
  logic [10:0]              pixel_column;
  logic [POS_W-1:0]         cam_x;
  logic [POS_W-1:0]         cam_y;
  logic [NUM_SPR*POS_W-1:0] spr_x;
  logic [NUM_SPR*POS_W-1:0] spr_y;
  logic [NUM_SPR-1:0]       spr_en;
  logic [NUM_SPR*ADDR_W-1:0]  spr_addr;
  logic [NUM_SPR*COLOR_W-1:0] spr_data;
  logic [BG_ADDR_W-1:0]     bg_addr;
  logic [COLOR_W-1:0]       bg_data;
  logic [COLOR_W:0]         pix_out;
  logic [LAYER_W-1:0]       pix_layer;

  modport master (
    output pixel_row, pixel_column, cam_x, cam_y, spr_x, spr_y, spr_en, spr_data, bg_data,
    input  spr_addr, bg_addr, pix_out, pix_layer
  );
  modport slave (
    input  pixel_row, pixel_column, cam_x, cam_y, spr_x, spr_y, spr_en, spr_data, bg_data,
    output spr_addr, bg_addr, pix_out, pix_layer
  );
endinterface

// File: rtl/sprite_hit_addr.sv
// One sprite channel: frame-latched position, box hit test and registered ROM address.
module sprite_hit_addr
  import sprite_pkg::*;
#(
  parameter int POS_W  = 12,
  parameter int ADDR_W = 14,
  parameter int SPR_W  = 128,
  parameter int SPR_H  = 128,
  parameter int SCR_W  = SCR_W_DEF,
  parameter int SCR_H  = SCR_H_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              latch,
  input  logic [10:0]       row,
  input  logic [10:0]       col,
  input  logic [POS_W-1:0]  cam_x,
  input  logic [POS_W-1:0]  cam_y,
  input  logic [POS_W-1:0]  spr_x,
  input  logic [POS_W-1:0]  spr_y,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              hit
);
  localparam coord_t OFF_X = coord_t'(SCR_W/2 - SPR_W/2);
  localparam coord_t OFF_Y = coord_t'(SCR_H/2 - SPR_H/2);

  logic [POS_W-1:0]  sx_sh, sy_sh, sx, sy;
  logic              en_sh, en_eff, hit_c;
  coord_t            ox, oy, dx, dy;
  logic [ADDR_W-1:0] lin;

  function automatic coord_t pos_ext(logic [POS_W-1:0] v);
    return coord_t'({{(COORD_W-POS_W){1'b0}}, v});
  endfunction

  // On the latch pixel itself the fresh inputs already belong to the new frame.
  assign sx     = latch ? spr_x : sx_sh;
  assign sy     = latch ? spr_y : sy_sh;
  assign en_eff = latch ? en    : en_sh;

  assign ox = pos_ext(sx) - pos_ext(cam_x) + OFF_X;
  assign oy = pos_ext(sy) - pos_ext(cam_y) + OFF_Y;
  assign dx = coord_t'({{(COORD_W-11){1'b0}}, col}) - ox;
  assign dy = coord_t'({{(COORD_W-11){1'b0}}, row}) - oy;

  assign hit_c = en_eff && in_span(dx, SPR_W) && in_span(dy, SPR_H);
  assign lin   = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);

  // Stage p1: address and hit registered
  always_ff @(posedge clk) begin
    if (reset) begin
      sx_sh <= '0;
      sy_sh <= '0;
      en_sh <= 1'b0;
      addr  <= '0;
      hit   <= 1'b0;
    end else begin
      if (latch) begin
        sx_sh <= spr_x;
        sy_sh <= spr_y;
        en_sh <= en;
      end
      hit  <= hit_c;
      addr <= hit_c ? lin : '0;
    end
  end
endmodule

// File: rtl/sprite_compositor.sv
// N-sprite priority compositor over a scaled background, 3-cycle pixel latency.
// Build option SPRITE_XPARENT_EN: sprite texels equal to the key colour are see-through.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPR   = NUM_SPR_DEF,
  parameter int SPR_W     = 128,
  parameter int SPR_H     = 128,
  parameter int SCR_W     = SCR_W_DEF,
  parameter int SCR_H     = SCR_H_DEF,
  parameter int POS_W     = 12,
  parameter int ADDR_W    = 14,
  parameter int COLOR_W   = 12,
  parameter int BG_SHIFT  = 2,
  parameter int BG_ADDR_W = 16
) (
  input logic clk,
  input logic reset,
  sprite_compositor_if.slave bus
);
  localparam int LAYER_W = $clog2(NUM_SPR) + 1;
  localparam logic [LAYER_W-1:0] LAYER_BG = LAYER_W'(layer_bg(NUM_SPR));

  logic                      latch;
  logic [POS_W-1:0]          cam_x_sh, cam_y_sh, cam_x_eff, cam_y_eff;
  logic [NUM_SPR*ADDR_W-1:0] spr_addr_p1;
  logic [NUM_SPR-1:0]        hit_p1, hit_p2, opaque;
  logic                      vld_p1, vld_p2;
  logic [BG_ADDR_W-1:0]      bg_lin;
  logic [LAYER_W-1:0]        sel_layer;
  logic [COLOR_W-1:0]        sel_rgb;

  assign latch     = (bus.pixel_row == 11'd0) && (bus.pixel_column == 11'd0);
  assign cam_x_eff = latch ? bus.cam_x : cam_x_sh;
  assign cam_y_eff = latch ? bus.cam_y : cam_y_sh;

  for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_spr
    sprite_hit_addr #(
      .POS_W(POS_W), .ADDR_W(ADDR_W), .SPR_W(SPR_W), .SPR_H(SPR_H),
      .SCR_W(SCR_W), .SCR_H(SCR_H)
    ) u_hit (
      .clk   (clk),
      .reset (reset),
      .latch (latch),
      .row   (bus.pixel_row),
      .col   (bus.pixel_column),
      .cam_x (cam_x_eff),
      .cam_y (cam_y_eff),
      .spr_x (bus.spr_x[gi*POS_W +: POS_W]),
      .spr_y (bus.spr_y[gi*POS_W +: POS_W]),
      .en    (bus.spr_en[gi]),
      .addr  (spr_addr_p1[gi*ADDR_W +: ADDR_W]),
      .hit   (hit_p1[gi])
    );
`ifdef SPRITE_XPARENT_EN
    assign opaque[gi] = bus.spr_data[gi*COLOR_W +: COLOR_W] != COLOR_W'(XPARENT_KEY);
`else
    assign opaque[gi] = 1'b1;
`endif
  end

  assign bus.spr_addr = spr_addr_p1;
  assign bg_lin = BG_ADDR_W'(bus.pixel_row >> BG_SHIFT) * BG_ADDR_W'(SCR_W >> BG_SHIFT)
                + BG_ADDR_W'(bus.pixel_column >> BG_SHIFT);

  // Lowest index wins; scan from the bottom so earlier sprites overwrite.
  always_comb begin
    sel_layer = LAYER_BG;
    sel_rgb   = bus.bg_data;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit_p2[i] && opaque[i]) begin
        sel_layer = LAYER_W'(i);
        sel_rgb   = bus.spr_data[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cam_x_sh      <= '0;
      cam_y_sh      <= '0;
      bus.bg_addr   <= '0;
      vld_p1        <= 1'b0;
      hit_p2        <= '0;
      vld_p2        <= 1'b0;
      bus.pix_out   <= '0;
      bus.pix_layer <= '0;
    end else begin
      if (latch) begin
        cam_x_sh <= bus.cam_x;
        cam_y_sh <= bus.cam_y;
      end
      // Stage p1: background address alongside sprite addresses
      bus.bg_addr   <= bg_lin;
      vld_p1        <= 1'b1;
      // Stage p2: ROM data arrives, hits delayed to match
      hit_p2        <= hit_p1;
      vld_p2        <= vld_p1;
      // Stage p3: composed pixel
      bus.pix_out   <= {vld_p2, sel_rgb};
      bus.pix_layer <= sel_layer;
    end
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// Randomized scoreboard bench for sprite_compositor against a pixel-level reference model.
module tb_sprite_compositor;
  import sprite_pkg::*;

  localparam int NS = 4, PW = 12, AW = 14, CW = 12, BW = 16, LW = 3;
`ifdef SPRITE_XPARENT_EN
  localparam bit XP = 1'b1;
`else
  localparam bit XP = 1'b0;
`endif

  typedef struct { int due; logic [NS*AW-1:0] sa; logic [BW-1:0] ba; } aexp_t;
  typedef struct { int due; logic [CW:0] pix; logic [LW-1:0] layer; } pexp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  aexp_t aq[$];
  pexp_t pq[$];
  aexp_t mon_a;
  pexp_t mon_p;

  int cur_cx, cur_cy, cur_sx[NS], cur_sy[NS];
  bit cur_en[NS];
  int m_cx, m_cy, m_sx[NS], m_sy[NS];
  bit m_en[NS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_compositor_if #(.NUM_SPR(NS), .POS_W(PW), .ADDR_W(AW), .COLOR_W(CW), .BG_ADDR_W(BW)) bus ();
  sprite_compositor #(.NUM_SPR(NS), .POS_W(PW), .ADDR_W(AW), .COLOR_W(CW), .BG_ADDR_W(BW))
    dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [CW-1:0] spr_rom(int i, int a);
    if (a % 23 == 0) return XPARENT_KEY;
    return CW'((a * 13 + i * 1000 + 1) % 4096);
  endfunction

  function automatic logic [CW-1:0] bg_rom(int a);
    return CW'((a * 5 + 3) % 4096);
  endfunction

  // Registered-output ROMs, one cycle of latency.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++)
      bus.spr_data[i*CW +: CW] <= spr_rom(i, int'(bus.spr_addr[i*AW +: AW]));
    bus.bg_data <= bg_rom(int'(bus.bg_addr));
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", nm, idx, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (aq.size() != 0 && aq[0].due <= cyc) begin
      mon_a = aq.pop_front();
      for (int i = 0; i < NS; i++)
        chk("spr_addr", i, 32'(bus.spr_addr[i*AW +: AW]), 32'(mon_a.sa[i*AW +: AW]));
      chk("bg_addr", 0, 32'(bus.bg_addr), 32'(mon_a.ba));
    end
    while (pq.size() != 0 && pq[0].due <= cyc) begin
      mon_p = pq.pop_front();
      chk("pix_out", 0, 32'(bus.pix_out), 32'(mon_p.pix));
      chk("pix_layer", 0, 32'(bus.pix_layer), 32'(mon_p.layer));
    end
  end

  task automatic set_cam(input int x, input int y);
    cur_cx = x; cur_cy = y;
    bus.cam_x = PW'(x); bus.cam_y = PW'(y);
  endtask

  task automatic set_spr(input int i, input int x, input int y, input bit en);
    cur_sx[i] = x; cur_sy[i] = y; cur_en[i] = en;
    bus.spr_x[i*PW +: PW] = PW'(x);
    bus.spr_y[i*PW +: PW] = PW'(y);
    bus.spr_en[i] = en;
  endtask

  task automatic idle();
    @(negedge clk); #1;
    bus.pixel_row = 11'd1; bus.pixel_column = 11'd1;
  endtask

  // Drive one pixel and queue what the display should show for it.
  task automatic issue(input int row, input int col);
    aexp_t ae;
    pexp_t pe;
    int ox, oy, dx, dy, a, bga, layer;
    bit hit, found;
    logic [CW-1:0] rgb, t;
    @(negedge clk); #1;
    bus.pixel_row = 11'(row); bus.pixel_column = 11'(col);
    if (row == 0 && col == 0) begin
      m_cx = cur_cx; m_cy = cur_cy;
      for (int i = 0; i < NS; i++) begin
        m_sx[i] = cur_sx[i]; m_sy[i] = cur_sy[i]; m_en[i] = cur_en[i];
      end
    end
    bga = ((row / 4) * (SCR_W_DEF / 4) + col / 4) % 65536;
    ae.due = cyc + 1; ae.ba = BW'(bga); ae.sa = '0;
    layer = NS; rgb = bg_rom(bga); found = 1'b0;
    for (int i = 0; i < NS; i++) begin
      ox = m_sx[i] - m_cx + SCR_W_DEF / 2 - 64;
      oy = m_sy[i] - m_cy + SCR_H_DEF / 2 - 64;
      dx = col - ox; dy = row - oy;
      hit = m_en[i] && dx >= 0 && dx < 128 && dy >= 0 && dy < 128;
      a = hit ? (dy * 128 + dx) % 16384 : 0;
      ae.sa[i*AW +: AW] = AW'(a);
      if (hit && !found) begin
        t = spr_rom(i, a);
        if (!XP || t != XPARENT_KEY) begin
          found = 1'b1; layer = i; rgb = t;
        end
      end
    end
    pe.due = cyc + 3; pe.pix = {1'b1, rgb}; pe.layer = LW'(layer);
    aq.push_back(ae);
    pq.push_back(pe);
  endtask

  task automatic do_reset();
    aexp_t ae;
    pexp_t pe;
    @(negedge clk); #1;
    reset = 1'b1;
    bus.pixel_row = 11'd5; bus.pixel_column = 11'd5;
    aq.delete(); pq.delete();
    m_cx = 0; m_cy = 0;
    for (int i = 0; i < NS; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_en[i] = 1'b0;
    end
    ae.due = cyc + 1; ae.sa = '0; ae.ba = '0;
    pe.due = cyc + 1; pe.pix = '0; pe.layer = '0;
    aq.push_back(ae);
    pq.push_back(pe);
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int cx, cy;
    bus.pixel_row = 11'd5; bus.pixel_column = 11'd5;
    set_cam(0, 0);
    for (int i = 0; i < NS; i++) set_spr(i, 0, 0, 1'b0);
    do_reset();

    // Hero centred, second sprite fully off the left edge.
    idle();
    set_cam(2000, 1500);
    set_spr(0, 2000, 1500, 1'b1);
    set_spr(1, 1400, 1500, 1'b1);
    issue(0, 0);
    issue(320, 448); issue(447, 575); issue(400, 500); issue(320, 447);
    issue(319, 448); issue(448, 575); issue(320, 576); issue(0, 4);
    for (int p = 0; p < 20; p++) issue($urandom_range(300, 460), $urandom_range(0, 200));

    // Partly clipped box at the left edge.
    idle();
    set_spr(1, 1500, 1500, 1'b1);
    issue(0, 0);
    issue(320, 0); issue(320, 75); issue(320, 76); issue(447, 10);

    // Overlap, then enable change that must wait for the next frame latch.
    idle();
    set_spr(1, 2000, 1500, 1'b1);
    issue(0, 0);
    issue(321, 449); issue(350, 500); issue(320, 448);
    idle();
    set_spr(0, 2000, 1500, 1'b0);
    issue(321, 449); issue(350, 500); issue(320, 448);
    issue(0, 0);
    issue(321, 449); issue(350, 500); issue(320, 448);

    // Mid-line reset: background only until the next latch.
    idle();
    set_spr(0, 2000, 1500, 1'b1);
    issue(0, 0);
    issue(330, 460); issue(331, 461);
    do_reset();
    issue(330, 460); issue(400, 500); issue(331, 461);
    issue(0, 0);
    issue(330, 460); issue(400, 500);

    for (int f = 0; f < 6; f++) begin
      idle();
      cx = int'($urandom_range(700, 3300));
      cy = int'($urandom_range(700, 3300));
      set_cam(cx, cy);
      for (int i = 0; i < NS; i++)
        set_spr(i, cx + int'($urandom_range(0, 1400)) - 700,
                   cy + int'($urandom_range(0, 1000)) - 500, $urandom_range(0, 3) != 0);
      issue(0, 0);
      for (int p = 0; p < 150; p++) begin
        if ($urandom_range(0, 1) == 1) issue($urandom_range(250, 520), $urandom_range(350, 680));
        else issue($urandom_range(0, 767), $urandom_range(0, 1023));
      end
    end

    for (int k = 0; k < 10 && (aq.size() != 0 || pq.size() != 0); k++) @(negedge clk);
    @(negedge clk);
    if (aq.size() != 0 || pq.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain pending=%0d want=0", aq.size() + pq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
